// File: rtl/reset_seq_pkg.sv
//==============================================================================
// Module      : reset_seq_pkg
// Description : Shared definitions for the reset sequencer: reset-level
//               literals, FSM state encodings and reset-cause codes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package reset_seq_pkg;

    // Reset-level literals: every reset output in this block is active-low.
    localparam logic RESET_ENABLE  = 1'b0;
    localparam logic RESET_DISABLE = 1'b1;

    // Plain status-flag literals.
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Binary FSM state encodings.
    localparam logic [1:0] STATE_HOLD   = 2'd0;
    localparam logic [1:0] STATE_BUS    = 2'd1;
    localparam logic [1:0] STATE_PERIPH = 2'd2;
    localparam logic [1:0] STATE_RUN    = 2'd3;

    // Cause of the most recent reset, as presented on reset_cause.
    typedef enum logic [1:0] {
        CAUSE_POR  = 2'b00,
        CAUSE_LOCK = 2'b01,
        CAUSE_SOFT = 2'b10,
        CAUSE_RSVD = 2'b11
    } cause_e;

endpackage : reset_seq_pkg

`default_nettype wire

// File: rtl/reset_seq_if.sv
//==============================================================================
// Module      : reset_seq_if
// Description : Signal bundle between the reset sequencer and the rest of
//               the chip: lock flag and soft request in, staged resets and
//               status out.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface reset_seq_if;

    logic       locked;
    logic       soft_rst_req;
    logic       bus_reset;
    logic       periph_reset;
    logic       cpu_reset;
    logic       reset_done;
    logic [1:0] reset_cause;

    // Sequencer side: consumes lock/request, drives resets and status.
    modport master (
        input  locked,
        input  soft_rst_req,
        output bus_reset,
        output periph_reset,
        output cpu_reset,
        output reset_done,
        output reset_cause
    );

    // Chip side: supplies lock/request, receives resets and status.
    modport slave (
        output locked,
        output soft_rst_req,
        input  bus_reset,
        input  periph_reset,
        input  cpu_reset,
        input  reset_done,
        input  reset_cause
    );

endinterface : reset_seq_if

`default_nettype wire

// File: rtl/sync_ff.sv
//==============================================================================
// Module      : sync_ff
// Description : N-stage single-bit synchronizer with asynchronous
//               active-low clear. Output is the last stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_ff #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the asynchronous input one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_d};
    end

    // Synchronizer chain, cleared to 0 while the reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule : sync_ff

`default_nettype wire

// File: rtl/reset_seq.sv
//==============================================================================
// Module      : reset_seq
// Description : Reset sequencer. Waits for the synchronized DCM lock flag to
//               stay high for STABLE_CYCLES, then releases bus, peripheral
//               and CPU resets STAGE_GAP cycles apart. Lock loss or a soft
//               request in RUN restarts the sequence; the cause of the last
//               reset is recorded.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 16
) (
    input  wire logic   clk,
    input  wire logic   reset,
    reset_seq_if.master rif
);

    localparam int STAB_W = $clog2(STABLE_CYCLES);
    localparam int GAP_W  = $clog2(STAGE_GAP);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

    logic               locked_s;

    logic [1:0]         state_q,  state_d;
    logic [STAB_W-1:0]  stab_q,   stab_d;
    logic [GAP_W-1:0]   gap_q,    gap_d;
    logic               bus_q,    bus_d;
    logic               periph_q, periph_d;
    logic               cpu_q,    cpu_d;
    logic               done_q,   done_d;
    cause_e             cause_q,  cause_d;

    logic               hold_req;
    cause_e             hold_cause;

    // The lock flag comes from the DCM clock domain; bring it onto clk.
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (reset),
        .i_d   (rif.locked),
        .o_q   (locked_s)
    );

    // Next-state and next-output logic; outputs are registered alongside state.
    always_comb begin
        state_d    = state_q;
        stab_d     = stab_q;
        gap_d      = gap_q;
        bus_d      = bus_q;
        periph_d   = periph_q;
        cpu_d      = cpu_q;
        done_d     = done_q;
        cause_d    = cause_q;
        hold_req   = 1'b0;
        hold_cause = cause_q;

        case (state_q)
            STATE_HOLD: begin
                // Any low sample restarts the stability window from zero.
                if (locked_s) begin
                    if (stab_q == STAB_LAST) begin
                        state_d = STATE_BUS;
                        bus_d   = RESET_DISABLE;
                        gap_d   = '0;
                        stab_d  = '0;
                    end else begin
                        stab_d = stab_q + STAB_ONE;
                    end
                end else begin
                    stab_d = '0;
                end
            end

            STATE_BUS: begin
                if (!locked_s) begin
                    hold_req   = 1'b1;
                    hold_cause = CAUSE_LOCK;
                end else if (gap_q == GAP_LAST) begin
                    state_d  = STATE_PERIPH;
                    periph_d = RESET_DISABLE;
                    gap_d    = '0;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end

            STATE_PERIPH: begin
                if (!locked_s) begin
                    hold_req   = 1'b1;
                    hold_cause = CAUSE_LOCK;
                end else if (gap_q == GAP_LAST) begin
                    state_d = STATE_RUN;
                    cpu_d   = RESET_DISABLE;
                    done_d  = ENABLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end

            STATE_RUN: begin
                // Lock loss takes precedence over a coincident soft request.
                if (!locked_s) begin
                    hold_req   = 1'b1;
                    hold_cause = CAUSE_LOCK;
                end else if (rif.soft_rst_req) begin
                    hold_req   = 1'b1;
                    hold_cause = CAUSE_SOFT;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a safe, fully-held state.
                hold_req = 1'b1;
            end
        endcase

        if (hold_req) begin
            state_d  = STATE_HOLD;
            stab_d   = '0;
            gap_d    = '0;
            bus_d    = RESET_ENABLE;
            periph_d = RESET_ENABLE;
            cpu_d    = RESET_ENABLE;
            done_d   = DISABLE;
            cause_d  = hold_cause;
        end
    end

    // State, counters and output flops; asynchronous assertion of chip reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= STATE_HOLD;
            stab_q   <= '0;
            gap_q    <= '0;
            bus_q    <= RESET_ENABLE;
            periph_q <= RESET_ENABLE;
            cpu_q    <= RESET_ENABLE;
            done_q   <= DISABLE;
            cause_q  <= CAUSE_POR;
        end else begin
            state_q  <= state_d;
            stab_q   <= stab_d;
            gap_q    <= gap_d;
            bus_q    <= bus_d;
            periph_q <= periph_d;
            cpu_q    <= cpu_d;
            done_q   <= done_d;
            cause_q  <= cause_d;
        end
    end

    assign rif.bus_reset    = bus_q;
    assign rif.periph_reset = periph_q;
    assign rif.cpu_reset    = cpu_q;
    assign rif.reset_done   = done_q;
    assign rif.reset_cause  = cause_q;

endmodule : reset_seq

`default_nettype wire

// File: tb/tb_reset_seq.sv
//==============================================================================
// Module      : tb_reset_seq
// Description : Self-checking bench for reset_seq. Directed release-timing
//               scenarios followed by randomized lock/soft-request traffic,
//               all compared against a progress-count reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_reset_seq;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 16;
    localparam int STAGE_GAP     = 4;
    localparam int PERIPH_AT     = STABLE_CYCLES + STAGE_GAP;
    localparam int RUN_AT        = STABLE_CYCLES + 2 * STAGE_GAP;
    localparam int LAT_BUS       = SYNC_STAGES - 1 + STABLE_CYCLES;

    logic clk = 1'b0;
    logic reset;

    reset_seq_if rif();

    reset_seq #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .STAGE_GAP     (STAGE_GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rif   (rif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a lock-sample pipeline plus a single progress count of
    // qualifying edges since the sequence (re)started.
    int                     m_p;
    logic [1:0]             m_cause;
    logic [SYNC_STAGES-1:0] m_sh;

    int   edge_no = 0;
    int   t_bus, t_per, t_done;
    logic prev_bus, prev_per, prev_done;
    int   n0;

    task automatic chk(input string tag, input int obs, input int req);
        n_checks++;
        if (obs == req) n_pass++;
        else $display("FAIL %s at edge %0d: observed %0d, required %0d", tag, edge_no, obs, req);
    endtask

    function automatic void model_reset();
        m_p     = 0;
        m_cause = 2'b00;
        m_sh    = '0;
    endfunction

    function automatic void model_edge(input logic lk, input logic sr);
        logic ls;
        logic released;
        logic running;
        if (!reset) begin
            model_reset();
            return;
        end
        ls       = m_sh[SYNC_STAGES-1];
        m_sh     = {m_sh[SYNC_STAGES-2:0], lk};
        released = (m_p >= STABLE_CYCLES);
        running  = (m_p >= RUN_AT);
        if (released && !ls) begin
            m_p     = 0;
            m_cause = 2'b01;
        end else if (running && sr) begin
            m_p     = 0;
            m_cause = 2'b10;
        end else if (!released) begin
            m_p = ls ? m_p + 1 : 0;
        end else if (!running) begin
            m_p = m_p + 1;
        end
    endfunction

    // One clock: drive inputs, let the edge happen, compare on the falling edge.
    task automatic step(input logic lk, input logic sr);
        logic [3:0] exp_rst;
        rif.locked       = lk;
        rif.soft_rst_req = sr;
        @(posedge clk);
        model_edge(lk, sr);
        edge_no++;
        @(negedge clk);
        exp_rst = {m_p >= STABLE_CYCLES, m_p >= PERIPH_AT, m_p >= RUN_AT, m_p >= RUN_AT};
        chk("resets", int'({rif.bus_reset, rif.periph_reset, rif.cpu_reset, rif.reset_done}),
            int'(exp_rst));
        chk("cause", int'(rif.reset_cause), int'(m_cause));
        if (rif.bus_reset && !prev_bus)     t_bus  = edge_no;
        if (rif.periph_reset && !prev_per)  t_per  = edge_no;
        if (rif.reset_done && !prev_done)   t_done = edge_no;
        prev_bus  = rif.bus_reset;
        prev_per  = rif.periph_reset;
        prev_done = rif.reset_done;
    endtask

    task automatic run_until_done(input int budget);
        int k = 0;
        while (!rif.reset_done && k < budget) begin
            step(1'b1, 1'b0);
            k++;
        end
        chk("done_within_budget", int'(rif.reset_done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        rif.locked       = 1'b0;
        rif.soft_rst_req = 1'b0;
        prev_bus  = 1'b0;
        prev_per  = 1'b0;
        prev_done = 1'b0;
        t_bus  = -1;
        t_per  = -1;
        t_done = -1;
        model_reset();
        @(negedge clk);

        // Power-on: reset held low, then lock arrives.
        repeat (5) step(1'b0, 1'b0);
        chk("por_bus_held", int'(rif.bus_reset), 0);
        chk("por_cause", int'(rif.reset_cause), 0);
        reset = 1'b1;
        step(1'b1, 1'b0);
        n0 = edge_no;
        run_until_done(60);
        chk("por_bus_lat",  t_bus  - n0, LAT_BUS);
        chk("por_per_lat",  t_per  - n0, LAT_BUS + STAGE_GAP);
        chk("por_done_lat", t_done - n0, LAT_BUS + 2 * STAGE_GAP);
        chk("por_cause_after", int'(rif.reset_cause), 0);

        // Lock loss in RUN: resets drop one edge after the synchronized flag falls.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("lockloss_still_run", int'(rif.reset_done), 1);
        step(1'b0, 1'b0);
        chk("lockloss_bus", int'(rif.bus_reset), 0);
        chk("lockloss_done", int'(rif.reset_done), 0);
        chk("lockloss_cause", int'(rif.reset_cause), 1);
        step(1'b1, 1'b0);
        n0 = edge_no;
        run_until_done(60);
        chk("relock_bus_lat",  t_bus  - n0, LAT_BUS);
        chk("relock_per_lat",  t_per  - n0, LAT_BUS + STAGE_GAP);
        chk("relock_done_lat", t_done - n0, LAT_BUS + 2 * STAGE_GAP);

        // Soft reset in RUN, then a request during BUS that must be ignored.
        step(1'b1, 1'b1);
        n0 = edge_no;
        chk("soft_bus", int'(rif.bus_reset), 0);
        chk("soft_cause", int'(rif.reset_cause), 2);
        for (int k = 0; k < 40 && !rif.bus_reset; k++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("soft_in_bus_ignored", int'(rif.bus_reset), 1);
        run_until_done(60);
        chk("soft_bus_lat",  t_bus  - n0, STABLE_CYCLES);
        chk("soft_per_lat",  t_per  - n0, STABLE_CYCLES + STAGE_GAP);
        chk("soft_done_lat", t_done - n0, STABLE_CYCLES + 2 * STAGE_GAP);

        // Lock loss and soft request on the same edge: lock loss wins.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("simul_cause", int'(rif.reset_cause), 1);
        chk("simul_done", int'(rif.reset_done), 0);

        // Asynchronous reset while in PERIPH, between clock edges.
        step(1'b1, 1'b0);
        for (int k = 0; k < 60 && !rif.periph_reset; k++) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("mid_in_periph", int'(rif.periph_reset && !rif.cpu_reset), 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_async_resets", int'({rif.bus_reset, rif.periph_reset, rif.cpu_reset, rif.reset_done}), 0);
        chk("mid_async_cause", int'(rif.reset_cause), 0);
        @(negedge clk);
        repeat (3) step(1'b1, 1'b0);
        reset = 1'b1;

        // Unstable lock: a one-cycle dropout restarts the stability count.
        repeat (10) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        n0 = edge_no;
        run_until_done(60);
        chk("unstable_bus_lat", t_bus - n0, LAT_BUS);

        // Randomized traffic with occasional chip resets.
        for (int i = 0; i < 2500; i++) begin
            logic lk;
            logic sr;
            lk = ($urandom_range(0, 59) != 0);
            sr = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                model_reset();
                step(lk, sr);
                reset = 1'b1;
            end else begin
                step(lk, sr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_reset_seq

`default_nettype wire

// File: doc/reset_seq.md
# reset_seq

Reset sequencer sitting directly downstream of `clk_gen`: its `reset` input is driven by `clk_gen`'s `chip_reset`, its `clk` by `clk_gen`'s `clk`, and it samples the DCM lock flag.
It requires lock to stay high for a programmable stable period, then releases the bus, peripheral and CPU resets in a fixed, spaced order.
It re-enters the sequence on lock loss or on a software reset request, and it records the cause of the last reset.

## Interface
- `SYNC_STAGES`, 2 — flip-flop depth of the `locked` synchronizer; legal range ≥2.
- `STABLE_CYCLES`, 1024 — consecutive synchronized-lock-high cycles required before the first release; legal range ≥2.
- `STAGE_GAP`, 16 — cycles between successive releases; legal range ≥2.
- `clk`  in  1 — system clock.
- `reset`  in  1 — asynchronous, active-low reset, driven by `chip_reset`.
- `locked`  in  1 — DCM lock flag; asynchronous to `clk` and synchronized internally.
- `soft_rst_req`  in  1 — synchronous single-cycle software reset request from the CPU.
- `bus_reset`  out  1 — active-low reset for the bus and arbiter.
- `periph_reset`  out  1 — active-low reset for I/O peripherals.
- `cpu_reset`  out  1 — active-low reset for the CPU core.
- `reset_done`  out  1 — high once the sequence has completed (`RUN` state).
- `reset_cause`  out  2 — cause of the last reset: 00 power-on, 01 lock loss, 10 soft, 11 reserved.

## Operation
- FSM states: `HOLD`, `BUS`, `PERIPH`, `RUN`. The state register is one-hot or binary. All outputs are dedicated flops loaded on the same edge as the state transition, so no decode glitches reach the outputs.
- `HOLD`: all three resets asserted (0), `reset_done`=0.
  - `stab_cnt` increments on each edge with `locked_s`=1 and clears on `locked_s`=0.
  - On an edge with `locked_s`=1 and `stab_cnt`==`STABLE_CYCLES`-1: go to `BUS`, `bus_reset`←1, `gap_cnt`←0.
- `BUS`: `gap_cnt` increments. At `gap_cnt`==`STAGE_GAP`-1: go to `PERIPH`, `periph_reset`←1, `gap_cnt`←0.
- `PERIPH`: same counting. At terminal count: go to `RUN`, `cpu_reset`←1, `reset_done`←1.
- `RUN`: holds until a lock-loss or soft-reset event.
- Lock loss: `locked_s`=0 in `BUS`, `PERIPH` or `RUN`.
  - Next edge: all resets←0, `reset_done`←0, state←`HOLD`, `stab_cnt`←0, `reset_cause`←01.
- Soft reset: `soft_rst_req`=1 in `RUN` with `locked_s`=1.
  - Next edge: all resets←0, `reset_done`←0, state←`HOLD`, `stab_cnt`←0, `reset_cause`←10.
  - The full `STABLE_CYCLES` count is re-run.
- `soft_rst_req` is ignored outside `RUN`.
- Simultaneous lock loss and soft request: lock loss wins, cause=01.
- `reset_cause` is held until the next event and is not cleared by sequence completion.
- Counter widths: `stab_cnt` is `$clog2(STABLE_CYCLES)` bits and `gap_cnt` is `$clog2(STAGE_GAP)` bits. Counters never wrap: they are compared for equality with the terminal value and then cleared.

## Timing
- Async reset (`reset`=0): immediately state=`HOLD`, `bus_reset`=`periph_reset`=`cpu_reset`=0, `reset_done`=0, `reset_cause`=00, counters 0, synchronizer flops 0.
  - Assertion is asynchronous; every deassertion is synchronous to `clk`.
- Let edge N be the first edge at which synchronizer stage 1 captures `locked`=1, with `locked` held high afterwards.
  - `locked_s`=1 after edge N+`SYNC_STAGES`-1.
  - `bus_reset` rises at edge N+`SYNC_STAGES`-1+`STABLE_CYCLES`.
  - `periph_reset` rises at that edge +`STAGE_GAP`.
  - `cpu_reset` and `reset_done` rise at that edge +2·`STAGE_GAP`.
- A `locked` glitch shorter than one cycle may be missed; a missed glitch is acceptable.
- A low `locked_s` in `HOLD` restarts the stable count from 0.
- Lock-loss or soft-reset assertion of the resets: one edge after `locked_s` falls or the request is sampled.
- `reset` falling mid-sequence overrides everything asynchronously, and cause returns to 00.

## Structure
- Shared header `reset_seq.h`: state encodings and the cause codes `CAUSE_POR`, `CAUSE_LOCK`, `CAUSE_SOFT`.
  - The existing `RESET_ENABLE`/`RESET_DISABLE` and `ENABLE`/`DISABLE` macros from `stddef.h` are used for all reset-level literals.
- One sub-module: `sync_ff`, a parameterized N-stage bit synchronizer with async active-low clear, instantiated for `locked`.
- Everything else (FSM, two counters, output flops) lives in `reset_seq`, about 150–200 lines.

## Test plan
All scenarios use `SYNC_STAGES`=2, `STABLE_CYCLES`=16, `STAGE_GAP`=4.
- Power-on: `reset` low for 5 cycles, `locked` high at edge N → `bus_reset` rises at N+17, `periph_reset` at N+21, `cpu_reset` and `reset_done` at N+25, `reset_cause`=00 throughout.
- Unstable lock: `locked` high for 10 cycles, low for 1 cycle, then high → the count restarts, and `bus_reset` rises 17 edges after the re-rise.
- Lock loss in `RUN`: `locked` driven low → all resets 0 and `reset_done`=0 on the edge after `locked_s` falls, `reset_cause`=01. On lock return the full 17/21/25 sequence replays.
- Soft reset: `soft_rst_req` pulsed in `RUN` → all resets 0 on the next edge, `reset_cause`=10, release after 16/20/24 further edges. A pulse sent during `BUS` produces no effect.
- Simultaneous events: `soft_rst_req`=1 on the same edge `locked_s` falls → `reset_cause`=01.
- Mid-sequence async reset: `reset` pulled low while in `PERIPH` → outputs go 0 without waiting for a clock edge, `reset_cause`=00, state `HOLD`.
